// File: rtl/boot_loader.sv
// Byte-stream program loader: assembles little-endian words into instruction memory, then releases the core.
// Optional trailing 32-bit image checksum enabled by defining BOOT_LOADER_CHECKSUM_EN.
module boot_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  output logic                  byte_ready_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  core_rst_no,
  output logic                  fetch_enable_o,
  output logic                  done_o,
  output logic                  error_o
);

  // state | meaning
  // HDR   | collecting the 4-byte word count
  // LOAD  | collecting image words, one memory write per word
  // CSUM  | collecting the 4-byte checksum (checksum build only)
  // DONE  | image loaded, core released (sticky)
  // ERROR | load aborted, core held in reset (sticky)
  typedef enum logic [2:0] {
    HDR,
    LOAD,
`ifdef BOOT_LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERROR
  } state_t;

  localparam logic [32:0]           CAP    = 33'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [31:0]           asm_q, asm_d;
  logic [31:0]           rem_q, rem_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  ready_q, ready_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  done_q, error_q, error_d;
  logic                  xfer;
  logic [31:0]           word;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [31:0]           sum_q, sum_d;
`endif

  assign xfer = byte_valid_i && ready_q;
  assign word = {byte_i, asm_q[31:8]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    if (xfer) begin
      asm_d = word;
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        case (state_q)
          HDR: begin
            rem_d = word;
            idx_d = '0;
            if (word == 32'd0 || {1'b0, word} > CAP) state_d = ERROR;
            else                                     state_d = LOAD;
          end
          LOAD: begin
            we_d    = 1'b1;
            addr_d  = BASE_A + idx_q;
            wdata_d = word;
            idx_d   = idx_q + 1'b1;
            rem_d   = rem_q - 32'd1;
`ifdef BOOT_LOADER_CHECKSUM_EN
            sum_d   = sum_q + word;
            if (rem_q == 32'd1) state_d = CSUM;
`else
            if (rem_q == 32'd1) state_d = DONE;
`endif
          end
`ifdef BOOT_LOADER_CHECKSUM_EN
          CSUM: state_d = (word == sum_q) ? DONE : ERROR;
`endif
          default: ;
        endcase
      end
    end
  end

  // Header errors show immediately; checksum errors surface one cycle later like release.
`ifdef BOOT_LOADER_CHECKSUM_EN
  assign ready_d = (state_d == HDR) || (state_d == LOAD) || (state_d == CSUM);
`else
  assign ready_d = (state_d == HDR) || (state_d == LOAD);
`endif
  assign error_d = (state_q == ERROR) || (state_q == HDR && state_d == ERROR);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= HDR;
      cnt_q   <= '0;
      asm_q   <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= (state_q == DONE);
      error_q <= error_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign byte_ready_o   = ready_q;
  assign mem_we_o       = we_q;
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;
  assign core_rst_no    = done_q;
  assign fetch_enable_o = done_q;
  assign done_o         = done_q;
  assign error_o        = error_q;

endmodule

// File: doc/boot_loader.md
# boot_loader

Upstream program loader for the single-core SoC. Receives a byte stream from a host link (UART receiver or bench driver), assembles little-endian 32-bit words and writes them into the SoC instruction memory through a dedicated write port. Holds the core in reset with fetch disabled until the image is fully written, then releases it. Replaces back-door `$readmemb` preloading of the instruction memory, so the same image load works in simulation and on FPGA.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: instruction-memory word-address width; image capacity is 2^ADDR_WIDTH words.
- `BASE_ADDR`, 0: word address of the first image word.

Ports:
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `byte_valid_i`  in  1  input byte present.
- `byte_i`  in  8  input byte.
- `byte_ready_o`  out  1  loader accepts a byte; transfer when `byte_valid_i && byte_ready_o` at a rising edge.
- `mem_we_o`  out  1  instruction-memory write strobe, one cycle per word.
- `mem_addr_o`  out  ADDR_WIDTH  word address.
- `mem_wdata_o`  out  32  write data.
- `core_rst_no`  out  1  active-low reset to the core.
- `fetch_enable_o`  out  1  drives the core `fetch_enable_i`.
- `done_o`  out  1  image loaded, core released.
- `error_o`  out  1  load aborted.

## Operation
- Stream format: 4-byte word count N (little-endian), then N words, each 4 bytes little-endian (first byte = bits 7:0); with `BOOT_LOADER_CHECKSUM_EN`, then 4-byte checksum.
- States: HDR (collect N), LOAD (collect words), CSUM (checksum only), DONE, ERROR.
- HDR: after 4th byte, N==0 or N>2^ADDR_WIDTH -> ERROR; else -> LOAD, word index 0.
- LOAD: byte counter 0..3 shifts bytes into the assembly register. On 4th byte: register `mem_wdata_o` = assembled word, `mem_addr_o` = BASE_ADDR + index (modulo 2^ADDR_WIDTH), pulse `mem_we_o`; index increments. After word N-1 -> DONE (or CSUM).
- DONE: `core_rst_no`=1, `fetch_enable_o`=1, `done_o`=1, `byte_ready_o`=0. Sticky until reset.
- ERROR: `error_o`=1, `byte_ready_o`=0, core held in reset, fetch low. Sticky until reset.
- Bytes are never dropped: `byte_ready_o` stays 1 throughout HDR/LOAD/CSUM, including cycles with `mem_we_o` high (memory port always accepts).
- Input gaps (`byte_valid_i`=0) stall the byte counter; no timeout.

## Timing
- Reset (edge with `rst_ni`=0): state HDR, counters/index/checksum 0, all outputs 0 (`byte_ready_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0, `core_rst_no`=0, `fetch_enable_o`=0, `done_o`=0, `error_o`=0). `byte_ready_o` rises the first cycle after `rst_ni` sampled high.
- Reset mid-load: aborts immediately; already-written memory words are not cleared; core returns to reset; next stream restarts at HDR.
- Word write: 4th byte accepted at edge E -> `mem_we_o`=1 with addr/data valid for cycle E..E+1 exactly.
- Release without checksum: last word's 4th byte at edge E -> DONE at edge E+1 (same edge the final write commits); `core_rst_no`/`fetch_enable_o`/`done_o` high from E+1.
- Header error: 4th header byte at edge E -> `error_o` high from E.
- Throughput: one byte per cycle sustained; a word every 4 cycles.

## Configuration
- `BOOT_LOADER_CHECKSUM_EN` defined: after LOAD enter CSUM; running checksum = 32-bit sum (mod 2^32) of all N image words. 4th checksum byte accepted at edge E -> DONE if equal, else ERROR, outputs updated from E+1. Memory already written is not cleared on mismatch.
- Undefined: no CSUM state, no checksum logic; LOAD -> DONE directly; any trailing bytes are not accepted (`byte_ready_o`=0).

## Test plan
- Load N=3 words 0x00000093,0x00100113,0x002081B3 back-to-back -> three `mem_we_o` pulses at addrs 0,1,2 with those data 4 cycles apart; `core_rst_no`/`fetch_enable_o` high the cycle after third pulse; fibonacci image run to `mem_flag`!=0.
- Same stream with `byte_valid_i` low for 1-5 random cycles between bytes -> identical writes, no byte loss.
- Header N=0, then N=2^ADDR_WIDTH+1 -> `error_o`=1, no `mem_we_o`, `fetch_enable_o` stays 0, `byte_ready_o`=0.
- `rst_ni` low for 1 cycle after 6 bytes of a N=4 load -> outputs 0, state HDR; full reload of N=2 succeeds at addrs 0,1.
- `BOOT_LOADER_CHECKSUM_EN`: words 1,2,3 with checksum 6 -> `done_o`=1; checksum 7 -> `error_o`=1, core held in reset.
- BASE_ADDR=1020, ADDR_WIDTH=10, N=6 -> writes at 1020..1023, 0, 1.
